// File: rtl/utype_instr_encoder_pkg.sv
// Shared U-type constants: opcodes, field positions and the encoder FSM state type.
// The U-type decode side imports the same definitions.
package utype_instr_encoder_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam int IMM_MSB = 31;
    localparam int IMM_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } enc_state_e;

    function automatic logic [6:0] utype_opcode(input logic auipc);
        return auipc ? OPC_AUIPC : OPC_LUI;
    endfunction

endpackage

// File: rtl/utype_instr_encoder_word_pack.sv
// Combinational U-type field packer with upper-immediate legality check.
// Shared with the assembler model so both build words identically.
module utype_word_pack
    import utype_instr_encoder_pkg::*;
(
    input  logic        auipc,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word                    = '0;
        word[IMM_MSB:IMM_LSB]   = imm[IMM_MSB:IMM_LSB];
        word[RD_MSB:RD_LSB]     = rd;
        word[OPC_MSB:OPC_LSB]   = utype_opcode(auipc);
        // Low immediate bits cannot be represented in a U-type word.
        legal                   = (imm[IMM_LSB-1:0] == '0);
    end

endmodule

// File: rtl/utype_instr_encoder.sv
// Encodes LUI/AUIPC requests and writes them sequentially into instruction memory,
// holding each write until acknowledged and stopping once DEPTH words are committed.
module utype_instr_encoder
    import utype_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = 32,
    localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_auipc,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  word_count,
    output logic              full,
    output logic              err,
    output logic              err_sticky
);

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    enc_state_e  state, state_nxt;
    logic [31:0] word_d;
    logic        legal_d;
    logic        accept;
    logic        commit;
    logic        last_commit;

    utype_word_pack u_pack (
        .auipc (in_auipc),
        .rd    (in_rd),
        .imm   (in_imm),
        .word  (word_d),
        .legal (legal_d)
    );

    assign mem_we = (state == WRITE);
    assign full   = (state == FULL);
    assign commit = (state == WRITE) && mem_ack;
    // A commit that fills the region must not accept a request it could never write.
    assign last_commit = commit && (word_count == LAST_CNT);

    always_comb begin
        in_ready = ((state == IDLE) || (commit && !last_commit)) && !full && !clear;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (accept && legal_d) state_nxt = WRITE;
                WRITE: begin
                    if (last_commit)              state_nxt = FULL;
                    else if (commit)              state_nxt = (accept && legal_d) ? WRITE : IDLE;
                end
                FULL:  state_nxt = FULL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            mem_addr   <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept && !legal_d;
            if (accept && !legal_d) err_sticky <= 1'b1;
            if (accept && legal_d)  mem_wdata  <= word_d;
            if (commit) begin
                mem_addr   <= mem_addr + WORD_STEP;
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule
